// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencer: steps a PC through a loadable 19-bit program memory and issues
// non-HALT words to cu over valid/ready. Define FETCH_LOOP_EN to wrap the PC at the last word instead of halting.
module instr_fetch_seq #(
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic               valid_nxt;
  logic [2:0]         opcode;
  logic               last_word;
  logic [INSTR_W-1:0] mem [DEPTH];

  assign opcode    = instr_out[INSTR_W-1 -: 3];
  assign last_word = (pc == ADDR_W'(DEPTH - 1));
  assign busy      = (state == S_FETCH) || (state == S_ISSUE);
  assign halted    = (state == S_HALT);

  // Program memory: loads only while the sequencer is not running; contents survive reset
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = instr_valid;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_nxt = S_FETCH;
          pc_nxt    = '0;
        end
      end
      S_FETCH: begin
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (!instr_valid) begin
          if (opcode == 3'b000) begin
            state_nxt = S_HALT;
          end else begin
            valid_nxt = 1'b1;
          end
        end else if (instr_ready) begin
          valid_nxt = 1'b0;
          if (last_word) begin
`ifdef FETCH_LOOP_EN
            pc_nxt    = '0;
            state_nxt = S_FETCH;
`else
            state_nxt = S_HALT;
`endif
          end else begin
            pc_nxt    = pc + ADDR_W'(1);
            state_nxt = S_FETCH;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr_valid <= valid_nxt;
    end
  end

  // Registered read of the current word; only FETCH updates it, so it is stable through ISSUE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out <= '0;
    end else if (state == S_FETCH) begin
      instr_out <= mem[pc];
    end
  end

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq; issued instructions are checked against a scoreboard queue.
module tb_instr_fetch_seq;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 16;
  localparam int INSTR_W = 19;
  localparam logic [INSTR_W-1:0] I0 = 19'b001_00100011_00010100;
  localparam logic [INSTR_W-1:0] I1 = 19'b010_00100011_00010100;

  logic               clk;
  logic               rst;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic               start;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc;
  logic               busy;
  logic               halted;

  int errors = 0;
  int checks = 0;
  logic [INSTR_W-1:0] exp_q [$];

  instr_fetch_seq #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .instr_ready(instr_ready), .instr_out(instr_out), .instr_valid(instr_valid),
    .pc(pc), .busy(busy), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: scoreboard any handshake at the negedge, then advance to just after the posedge
  task automatic step();
    logic [INSTR_W-1:0] e;
    @(negedge clk);
    if (instr_valid && instr_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got instr=%h pc=%0d, required no handshake", instr_out, pc);
      end else begin
        e = exp_q.pop_front();
        if (instr_out !== e) begin
          errors++;
          $display("FAIL issue_data: got %h required %h (pc=%0d)", instr_out, e, pc);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout: got valid=%b required 1", name, instr_valid);
    end
  endtask

  task automatic wait_halt(input string name, input logic [ADDR_W-1:0] exp_pc);
    for (int i = 0; i < 100 && !halted; i++) step();
    checks++;
    if (halted !== 1'b1 || pc !== exp_pc || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_halt: got halted=%b pc=%0d valid=%b required 1/%0d/0", name, halted, pc,
               instr_valid, exp_pc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d unissued, required 0", name, exp_q.size());
    end
  endtask

  task automatic load_basic_program();
    load_word(4'd0, I0);
    load_word(4'd1, I1);
    load_word(4'd2, 19'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0; instr_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({instr_valid, busy, halted} !== 3'b000 || pc !== 4'd0 || instr_out !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b b=%b h=%b pc=%0d out=%h required all 0", instr_valid,
               busy, halted, pc, instr_out);
    end
    for (int i = 0; i < 4; i++) begin
      instr_ready = ~instr_ready;
      step();
      checks++;
      if ({instr_valid, busy, halted} !== 3'b000 || pc !== 4'd0) begin
        errors++;
        $display("FAIL idle_ready_toggle: got v=%b b=%b h=%b pc=%0d required 0/0/0/0", instr_valid,
                 busy, halted, pc);
      end
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_basic();
    load_basic_program();
    exp_q.push_back(I0);
    exp_q.push_back(I1);
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_t0: got busy=%b valid=%b required 1/0", busy, instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_t1: got valid=%b required 0", instr_valid);
    end
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== I0 || pc !== 4'd0) begin
      errors++;
      $display("FAIL latency_t2: got valid=%b out=%h pc=%0d required 1/%h/0", instr_valid,
               instr_out, pc, I0);
    end
    instr_ready = 1'b1;
    wait_halt("basic", 4'd2);
    instr_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [INSTR_W-1:0] held_out;
    logic [ADDR_W-1:0]  held_pc;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("bp_first");
    held_out = instr_out;
    held_pc  = pc;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr_out !== held_out || pc !== held_pc) begin
        errors++;
        $display("FAIL bp_hold: got v=%b out=%h pc=%0d required 1/%h/%0d", instr_valid, instr_out,
                 pc, held_out, held_pc);
      end
    end
    exp_q.push_back(I0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || pc !== 4'd1) begin
      errors++;
      $display("FAIL bp_pulse: got v=%b pc=%0d required 0/1", instr_valid, pc);
    end
    wait_valid("bp_second");
    step();
    step();
    checks++;
    if (pc !== 4'd1 || instr_out !== I1 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_single: got pc=%0d out=%h v=%b required 1/%h/1", pc, instr_out,
               instr_valid, I1);
    end
    exp_q.push_back(I1);
    instr_ready = 1'b1;
    wait_halt("bp", 4'd2);
    instr_ready = 1'b0;
  endtask

  task automatic test_fill();
    logic [7:0] b;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'(i);
      load_word(4'(i), {3'b110, b, ~b});
    end
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'(i);
      exp_q.push_back({3'b110, b, ~b});
    end
`ifdef FETCH_LOOP_EN
    for (int i = 0; i < 3; i++) begin
      b = 8'(i);
      exp_q.push_back({3'b110, b, ~b});
    end
    start = 1'b1;
    step();
    start = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step();
    instr_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fill_loop_pending: got %0d unissued, required 0", exp_q.size());
    end
    wait_valid("fill_loop");
    checks++;
    if (pc !== 4'd3 || instr_out !== {3'b110, 8'd3, ~8'd3} || halted !== 1'b0) begin
      errors++;
      $display("FAIL fill_wrap: got pc=%0d out=%h halted=%b required 3/%h/0", pc, instr_out, halted,
               {3'b110, 8'd3, ~8'd3});
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
`else
    start = 1'b1;
    step();
    start = 1'b0;
    instr_ready = 1'b1;
    wait_halt("fill", 4'd15);
    instr_ready = 1'b0;
`endif
  endtask

  task automatic test_busy_ignore();
    load_basic_program();
    exp_q.push_back(I0);
    exp_q.push_back(I1);
    start = 1'b1;
    step();
    start = 1'b0;
    load_en = 1'b1; load_addr = 4'd1; load_data = 19'd0;
    step();
    load_en = 1'b0;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || pc !== 4'd0) begin
      errors++;
      $display("FAIL busy_start: got v=%b pc=%0d required 1/0", instr_valid, pc);
    end
    instr_ready = 1'b1;
    wait_halt("busy", 4'd2);
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid("rst_mid");
    rst = 1'b1;
    #1;
    checks++;
    if ({instr_valid, busy, halted} !== 3'b000 || pc !== 4'd0 || instr_out !== 19'd0) begin
      errors++;
      $display("FAIL rst_async: got v=%b b=%b h=%b pc=%0d out=%h required all 0", instr_valid, busy,
               halted, pc, instr_out);
    end
    step();
    rst = 1'b0;
    step();
    exp_q.push_back(I0);
    exp_q.push_back(I1);
    start = 1'b1;
    step();
    start = 1'b0;
    instr_ready = 1'b1;
    wait_halt("rerun", 4'd2);
    instr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fill();
    test_busy_ignore();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
